// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared types for the load/store unit: access size, LSU state
//                and a helper returning the byte count of an access size.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2
    } mem_op_sz_e;

    typedef enum logic [0:0] {
        LSU_IDLE  = 1'b0,
        LSU_SPLIT = 1'b1
    } lsu_state_e;

    // Number of bytes touched by one access of the given size.
    function automatic logic [2:0] mem_size_bytes(input mem_op_sz_e sz);
        case (sz)
            BYTE:    mem_size_bytes = 3'd1;
            HWORD:   mem_size_bytes = 3'd2;
            default: mem_size_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_ext
//  Description : Sign/zero extension of raw load data to 32 bits. Shared by the
//                aligned path (raw = memory read) and the split path (raw =
//                assembled byte buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_raw,
    input  mem_op_sz_e  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_ext
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_raw[7];
    assign w_sign_h = ~i_unsigned & i_raw[15];

    // Extend from bit 7 / bit 15; words pass through untouched.
    always_comb begin
        case (i_size)
            BYTE:    o_ext = {{24{w_sign_b}}, i_raw[7:0]};
            HWORD:   o_ext = {{16{w_sign_h}}, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : One-at-a-time load/store front end for data_mem. Checks range
//                and alignment; misaligned half/word accesses are either split
//                into single-byte accesses or faulted, so the memory only ever
//                sees naturally aligned accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MemoryBytesSize = 4,
    parameter bit          MisalignedSplit = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  mem_op_sz_e  i_req_size,
    output logic        o_resp_valid,
    output logic        o_resp_fault,
    output logic [31:0] o_resp_rdata,
    output logic        o_mem_we,
    output logic        o_mem_re,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output mem_op_sz_e  o_mem_size,
    input  logic [31:0] i_mem_rdata
);

    // First byte address past the end of memory; 33 bits so addr+N-1 never wraps.
    localparam logic [32:0] LIMIT_BYTES = 33'(MemoryBytesSize * 4);

    lsu_state_e  state_q,      state_d;
    logic [1:0]  k_q,          k_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        we_q,         we_d;
    mem_op_sz_e  size_q,       size_d;
    logic        uns_q,        uns_d;
    logic [31:0] buf_q,        buf_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [2:0]  w_req_bytes;
    logic [2:0]  w_cap_bytes;
    logic [32:0] w_end_addr;
    logic        w_range_fault;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_buf_merged;
    logic [31:0] w_ext_raw;
    mem_op_sz_e  w_ext_size;
    logic        w_ext_uns;
    logic [31:0] w_ext;

    assign w_req_bytes   = mem_size_bytes(i_req_size);
    assign w_cap_bytes   = mem_size_bytes(size_q);
    assign w_end_addr    = {1'b0, i_req_addr} + 33'(w_req_bytes) - 33'd1;
    assign w_range_fault = (w_end_addr >= LIMIT_BYTES);
    assign w_misaligned  = ((i_req_size == HWORD) && i_req_addr[0]) ||
                           ((i_req_size == WORD)  && (i_req_addr[1:0] != 2'b00));
    assign w_accept      = i_req_valid && (state_q == LSU_IDLE);
    assign w_last        = ({1'b0, k_q} == (w_cap_bytes - 3'd1));
    assign o_req_ready   = (state_q == LSU_IDLE);

    // Byte buffer with the byte arriving this cycle already merged in, so the
    // final split byte can be extended without waiting another cycle.
    always_comb begin
        w_buf_merged = buf_q;
        w_buf_merged[{k_q, 3'b000} +: 8] = i_mem_rdata[7:0];
    end

    // One extender serves both paths: split uses the assembled buffer and the
    // captured size/sign, the aligned path uses the live read and request.
    assign w_ext_raw  = (state_q == LSU_SPLIT) ? w_buf_merged : i_mem_rdata;
    assign w_ext_size = (state_q == LSU_SPLIT) ? size_q       : i_req_size;
    assign w_ext_uns  = (state_q == LSU_SPLIT) ? uns_q        : i_req_unsigned;

    lsu_load_ext u_load_ext (
        .i_raw      (w_ext_raw),
        .i_size     (w_ext_size),
        .i_unsigned (w_ext_uns),
        .o_ext      (w_ext)
    );

    // Next-state, memory port drive and response computation.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        buf_d        = buf_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        o_mem_we     = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_wdata  = 32'd0;
        o_mem_size   = BYTE;

        case (state_q)
            LSU_IDLE: begin
                if (w_accept) begin
                    if (w_range_fault || (w_misaligned && !MisalignedSplit)) begin
                        // Fault: no strobe, report next cycle.
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (w_misaligned) begin
                        // Byte 0 straight from the request, rest from captures.
                        o_mem_we    = i_req_we;
                        o_mem_re    = ~i_req_we;
                        o_mem_addr  = i_req_addr;
                        o_mem_size  = BYTE;
                        o_mem_wdata = {24'd0, i_req_wdata[7:0]};
                        addr_d      = i_req_addr;
                        wdata_d     = i_req_wdata;
                        we_d        = i_req_we;
                        size_d      = i_req_size;
                        uns_d       = i_req_unsigned;
                        buf_d       = {24'd0, i_mem_rdata[7:0]};
                        k_d         = 2'd1;
                        state_d     = LSU_SPLIT;
                    end else begin
                        o_mem_we     = i_req_we;
                        o_mem_re     = ~i_req_we;
                        o_mem_addr   = i_req_addr;
                        o_mem_size   = i_req_size;
                        o_mem_wdata  = i_req_wdata;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = i_req_we ? 32'd0 : w_ext;
                    end
                end
            end
            LSU_SPLIT: begin
                o_mem_we    = we_q;
                o_mem_re    = ~we_q;
                o_mem_addr  = addr_q + {30'd0, k_q};
                o_mem_size  = BYTE;
                o_mem_wdata = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
                buf_d       = w_buf_merged;
                k_d         = k_q + 2'd1;
                if (w_last) begin
                    k_d          = 2'd0;
                    state_d      = LSU_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : w_ext;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and registered response; reset aborts any split in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= LSU_IDLE;
            k_q          <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            we_q         <= 1'b0;
            size_q       <= BYTE;
            uns_q        <= 1'b0;
            buf_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            buf_q        <= buf_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign o_resp_valid = resp_valid_q;
    assign o_resp_fault = resp_fault_q;
    assign o_resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a 16-byte
//                behavioural data memory. Expected responses are queued at
//                request acceptance and compared when the DUT responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        ns_req_valid;
    logic        i_req_we;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    mem_op_sz_e  i_req_size;

    logic        o_req_ready,  ns_req_ready;
    logic        o_resp_valid, ns_resp_valid;
    logic        o_resp_fault, ns_resp_fault;
    logic [31:0] o_resp_rdata, ns_resp_rdata;
    logic        o_mem_we,     ns_mem_we;
    logic        o_mem_re,     ns_mem_re;
    logic [31:0] o_mem_addr,   ns_mem_addr;
    logic [31:0] o_mem_wdata,  ns_mem_wdata;
    mem_op_sz_e  o_mem_size,   ns_mem_size;
    logic [31:0] i_mem_rdata,  ns_mem_rdata;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [7:0]  mem     [16] = '{default: 8'h00};
    logic [7:0]  ref_mem [16] = '{default: 8'h00};
    int          w;

    always #5 i_clk = ~i_clk;

    load_store_unit #(.MemoryBytesSize(4), .MisalignedSplit(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
        .o_resp_valid(o_resp_valid), .o_resp_fault(o_resp_fault), .o_resp_rdata(o_resp_rdata),
        .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size), .i_mem_rdata(i_mem_rdata)
    );

    load_store_unit #(.MemoryBytesSize(4), .MisalignedSplit(1'b0)) dut_ns (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(ns_req_valid), .o_req_ready(ns_req_ready),
        .i_req_we(i_req_we), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
        .o_resp_valid(ns_resp_valid), .o_resp_fault(ns_resp_fault), .o_resp_rdata(ns_resp_rdata),
        .o_mem_we(ns_mem_we), .o_mem_re(ns_mem_re), .o_mem_addr(ns_mem_addr),
        .o_mem_wdata(ns_mem_wdata), .o_mem_size(ns_mem_size), .i_mem_rdata(ns_mem_rdata)
    );

    function automatic int nbytes(input mem_op_sz_e sz);
        return (sz == BYTE) ? 1 : (sz == HWORD) ? 2 : 4;
    endfunction

    // Behavioural data_mem: combinational read, write on the rising edge.
    always_comb begin
        i_mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(o_mem_size) && (int'(o_mem_addr) + i) < 16)
                i_mem_rdata[8*i +: 8] = mem[int'(o_mem_addr) + i];
    end

    always_comb begin
        ns_mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(ns_mem_size) && (int'(ns_mem_addr) + i) < 16)
                ns_mem_rdata[8*i +: 8] = mem[int'(ns_mem_addr) + i];
    end

    always @(posedge i_clk) begin
        if (o_mem_we)
            for (int i = 0; i < 4; i++)
                if (i < nbytes(o_mem_size) && (int'(o_mem_addr) + i) < 16)
                    mem[int'(o_mem_addr) + i] <= o_mem_wdata[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference load result from the bench's own memory image.
    function automatic logic [31:0] exp_load(input int addr, input mem_op_sz_e sz, input logic uns);
        logic [31:0] raw = 32'd0;
        for (int i = 0; i < nbytes(sz); i++) raw[8*i +: 8] = ref_mem[addr + i];
        if (sz == BYTE)  return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
        if (sz == HWORD) return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        return raw;
    endfunction

    // Response monitor: pops the scoreboard on each response pulse.
    always @(negedge i_clk) begin
        exp_t e;
        cyc++;
        if (i_rst_n && o_resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 32'(cyc), 32'(e.due));
                check("resp_fault", {31'd0, o_resp_fault}, {31'd0, e.fault});
                check("resp_rdata", o_resp_rdata, e.rdata);
            end
        end
    end

    // Present a request at the falling edge and hold it until accepted.
    task automatic send(input logic we, input logic uns, input int addr, input logic [31:0] wdata,
                        input mem_op_sz_e sz, input bit track, output int waited);
        bit          accepted = 0;
        bit          rdy;
        longint      last  = longint'(addr) + nbytes(sz) - 1;
        bit          fault = (last >= 16);
        bit          mis   = (sz == HWORD && addr[0]) || (sz == WORD && addr[1:0] != 2'b00);
        int          lat   = (!fault && mis) ? nbytes(sz) : 1;
        logic [31:0] rd    = (we || fault) ? 32'd0 : exp_load(addr, sz, uns);
        i_req_we       = we;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
        i_req_size     = sz;
        i_req_valid    = 1'b1;
        waited         = 0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            #1;
            rdy = o_req_ready;
            if (rdy && fault) check("fault_no_strobe", {30'd0, o_mem_re, o_mem_we}, 32'd0);
            @(posedge i_clk);
            if (rdy) accepted = 1;
            else     waited++;
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (track) begin
            sb.push_back('{fault, rd, cyc + lat});
            if (we && !fault)
                for (int i = 0; i < nbytes(sz); i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},      {31'd0, o_req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
        check({tag, "_resp_fault"}, {31'd0, o_resp_fault}, 32'd0);
        check({tag, "_resp_rdata"}, o_resp_rdata,          32'd0);
        check({tag, "_mem_strobe"}, {30'd0, o_mem_re, o_mem_we}, 32'd0);
        check({tag, "_mem_addr"},   o_mem_addr,            32'd0);
        check({tag, "_mem_size"},   {30'd0, o_mem_size},   {30'd0, BYTE});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        i_rst_n        = 1'b0;
        i_req_valid    = 1'b0;
        ns_req_valid   = 1'b0;
        i_req_we       = 1'b0;
        i_req_unsigned = 1'b0;
        i_req_addr     = 32'd0;
        i_req_wdata    = 32'd0;
        i_req_size     = BYTE;
        repeat (2) @(negedge i_clk);
        check_reset_outputs("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Word store then signed/unsigned byte loads of the top byte.
        send(1'b1, 1'b0, 0, 32'hDEADBEEF, WORD, 1, w);
        send(1'b0, 1'b0, 3, 32'd0, BYTE, 1, w);
        send(1'b0, 1'b1, 3, 32'd0, BYTE, 1, w);
        idle(2);

        // Misaligned halfword store split into two byte writes, then load back.
        send(1'b1, 1'b0, 5, 32'h00008001, HWORD, 1, w);
        check("split_ready_low", {31'd0, o_req_ready}, 32'd0);
        check("split_b1_addr",   o_mem_addr,  32'd6);
        check("split_b1_wdata",  o_mem_wdata, 32'h80);
        check("split_b1_we",     {30'd0, o_mem_re, o_mem_we}, 32'd1);
        check("split_b1_size",   {30'd0, o_mem_size}, {30'd0, BYTE});
        send(1'b0, 1'b0, 5, 32'd0, HWORD, 1, w);
        check("split_wait", 32'(w), 32'd1);
        idle(4);

        // Range boundary: last word, straddling word, last byte, one past end.
        send(1'b1, 1'b0, 12, 32'hCAFEF00D, WORD, 1, w);
        send(1'b0, 1'b0, 13, 32'd0, WORD, 1, w);
        send(1'b0, 1'b0, 12, 32'd0, WORD, 1, w);
        send(1'b0, 1'b0, 15, 32'd0, BYTE, 1, w);
        send(1'b0, 1'b1, 16, 32'd0, BYTE, 1, w);
        idle(2);

        // Reset in the middle of a split word store after the second byte.
        send(1'b1, 1'b0, 1, 32'h11223344, WORD, 0, w);
        i_req_valid = 1'b0;
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_mem1", {24'd0, mem[1]}, 32'h44);
        check("abort_mem2", {24'd0, mem[2]}, 32'h33);
        check("abort_mem3", {24'd0, mem[3]}, {24'd0, ref_mem[3]});
        check("abort_mem4", {24'd0, mem[4]}, {24'd0, ref_mem[4]});
        ref_mem[1] = 8'h44;
        ref_mem[2] = 8'h33;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Split disabled: misaligned word faults without touching memory.
        i_req_we = 1'b0; i_req_unsigned = 1'b0; i_req_size = WORD; i_req_addr = 32'd2;
        ns_req_valid = 1'b1;
        #1;
        check("ns_mis_no_strobe", {30'd0, ns_mem_re, ns_mem_we}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        ns_req_valid = 1'b0;
        check("ns_mis_valid", {31'd0, ns_resp_valid}, 32'd1);
        check("ns_mis_fault", {31'd0, ns_resp_fault}, 32'd1);
        check("ns_mis_rdata", ns_resp_rdata, 32'd0);
        i_req_addr = 32'd4;
        ns_req_valid = 1'b1;
        #1;
        check("ns_al_re",   {30'd0, ns_mem_re, ns_mem_we}, 32'd2);
        check("ns_al_addr", ns_mem_addr, 32'd4);
        @(posedge i_clk);
        @(negedge i_clk);
        ns_req_valid = 1'b0;
        check("ns_al_valid", {31'd0, ns_resp_valid}, 32'd1);
        check("ns_al_fault", {31'd0, ns_resp_fault}, 32'd0);
        check("ns_al_rdata", ns_resp_rdata, exp_load(4, WORD, 1'b0));
        @(negedge i_clk);

        // Back-to-back requests presented in the cycle the response pulses.
        send(1'b0, 1'b0, 0, 32'd0, WORD, 1, w);
        send(1'b0, 1'b1, 6, 32'd0, HWORD, 1, w);
        check("b2b_wait_1", 32'(w), 32'd0);
        send(1'b0, 1'b0, 9, 32'd0, WORD, 1, w);
        check("b2b_wait_2", 32'(w), 32'd0);
        send(1'b0, 1'b0, 6, 32'd0, BYTE, 1, w);
        check("b2b_wait_split", 32'(w), 32'd3);
        idle(8);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
